// File: rtl/dqn_pkg.sv
// Shared constants for the DQN training datapath.
// Activations use Q6.10 signed fixed point: 6 integer bits (sign included) and 10 fraction bits.
package dqn_pkg;

    localparam int DATA_W = 16;
    localparam int STEP_W = 4;
    localparam int CTRL_W = 4;

    localparam logic [CTRL_W-1:0] CTRL_FWD = 4'd1;
    localparam logic [CTRL_W-1:0] CTRL_BWD = 4'd2;
    localparam logic [CTRL_W-1:0] CTRL_UPD = 4'd3;

endpackage

// File: rtl/a_hist_buffer_lane.sv
// One channel of activation history: DEPTH x DATA_W storage.
// It has a single write port and two combinational read ports (read slot and last slot).
module a_hist_lane #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int PTR_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [PTR_W-1:0]  wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [PTR_W-1:0]  rd_addr,
    input  logic [PTR_W-1:0]  last_addr,
    output logic [DATA_W-1:0] rd_word,
    output logic [DATA_W-1:0] last_word
);

    logic [DATA_W-1:0] mem_r [DEPTH];

    // Storage write; reset clears every slot
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Out-of-range addresses (lags past a non-power-of-two depth) read as zero
    assign rd_word   = (int'(rd_addr) < DEPTH)   ? mem_r[rd_addr]   : '0;
    assign last_word = (int'(last_addr) < DEPTH) ? mem_r[last_addr] : '0;

endmodule

// File: rtl/a_hist_buffer.sv
// Activation history buffer: captures CH lanes once per forward step into a DEPTH-entry ring.
// Optional build macro A_HIST_STEP_GUARD_EN limits capture to once per step value.
module a_hist_buffer #(
    parameter int                            DATA_W        = dqn_pkg::DATA_W,
    parameter int                            CH            = 2,
    parameter int                            DEPTH         = 4,
    parameter logic [dqn_pkg::CTRL_W-1:0]    CAPTURE_PHASE = 4'd1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [dqn_pkg::STEP_W-1:0]   step,
    input  logic [dqn_pkg::CTRL_W-1:0]   controller,
    input  logic                         flush,
    input  logic [CH*DATA_W-1:0]         a_in,
    input  logic [$clog2(DEPTH)-1:0]     rd_lag,
    output logic [CH*DATA_W-1:0]         rd_data,
    output logic                         rd_valid,
    output logic [CH*DATA_W-1:0]         a_last,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         push
);

    import dqn_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int SUM_W = PTR_W + 2;
    localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);

    logic [PTR_W-1:0]    wr_ptr_r;
    logic [CNT_W-1:0]    count_r;
    logic [CH*DATA_W-1:0] rd_data_r;
    logic                rd_valid_r;
    logic                push_r;

    logic                guard_ok_s;
    logic                cap_s;
    logic                lag_ok_s;
    logic [SUM_W-1:0]    sum_s;
    logic [PTR_W-1:0]    rd_slot_s;
    logic [PTR_W-1:0]    last_slot_s;
    logic [CH*DATA_W-1:0] rd_word_s;
    logic [CH*DATA_W-1:0] last_word_s;

`ifdef A_HIST_STEP_GUARD_EN
    logic [STEP_W-1:0]   last_step_r;
    logic                armed_r;

    // Step guard: remember the step of the last capture until reset or flush
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            last_step_r <= '0;
            armed_r     <= 1'b0;
        end else if (cap_s) begin
            last_step_r <= step;
            armed_r     <= 1'b1;
        end
    end

    // Guard passes on a new step value or when nothing has been captured yet
    always_comb begin
        guard_ok_s = !armed_r || (step != last_step_r);
    end
`else
    // No guard: every qualifying cycle captures
    always_comb begin
        guard_ok_s = 1'b1;
    end
`endif

    // Capture qualification and read-slot arithmetic against the current write pointer
    always_comb begin
        cap_s    = (step != {STEP_W{1'b0}}) && (controller == CAPTURE_PHASE) && !flush && guard_ok_s;
        lag_ok_s = (CNT_W'(rd_lag) < count_r);
        sum_s    = SUM_W'(wr_ptr_r) + SUM_W'(DEPTH - 1) - SUM_W'(rd_lag);
        if (sum_s >= SUM_W'(DEPTH)) begin
            rd_slot_s = PTR_W'(sum_s - SUM_W'(DEPTH));
        end else begin
            rd_slot_s = sum_s[PTR_W-1:0];
        end
        if (wr_ptr_r == {PTR_W{1'b0}}) begin
            last_slot_s = LAST_SLOT;
        end else begin
            last_slot_s = wr_ptr_r - PTR_W'(1);
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_lane
        a_hist_lane #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .PTR_W  (PTR_W)
        ) u_lane (
            .clk       (clk),
            .rst       (rst),
            .wr_en     (cap_s),
            .wr_addr   (wr_ptr_r),
            .wr_data   (a_in[g*DATA_W +: DATA_W]),
            .rd_addr   (rd_slot_s),
            .last_addr (last_slot_s),
            .rd_word   (rd_word_s[g*DATA_W +: DATA_W]),
            .last_word (last_word_s[g*DATA_W +: DATA_W])
        );
    end

    // Pointer, occupancy, push pulse and registered read port
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_r   <= '0;
            count_r    <= '0;
            rd_data_r  <= '0;
            rd_valid_r <= 1'b0;
            push_r     <= 1'b0;
        end else begin
            push_r     <= cap_s;
            rd_valid_r <= lag_ok_s;
            rd_data_r  <= lag_ok_s ? rd_word_s : '0;
            if (cap_s) begin
                wr_ptr_r <= (wr_ptr_r == LAST_SLOT) ? '0 : (wr_ptr_r + PTR_W'(1));
                if (count_r != FULL_CNT) begin
                    count_r <= count_r + CNT_W'(1);
                end
            end
        end
    end

    assign rd_data  = rd_data_r;
    assign rd_valid = rd_valid_r;
    assign count    = count_r;
    assign push     = push_r;
    assign a_last   = (count_r == {CNT_W{1'b0}}) ? '0 : last_word_s;

endmodule

// File: tb/tb_a_hist_buffer.sv
// Scoreboard bench for a_hist_buffer: stimulus queues expected values, a negedge monitor pops and compares.
module tb_a_hist_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  step;
    logic [3:0]  controller;
    logic        flush;
    logic [31:0] a_in;
    logic [1:0]  rd_lag;
    logic [31:0] rd_data;
    logic        rd_valid;
    logic [31:0] a_last;
    logic [2:0]  count;
    logic        push;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } item_t;

    item_t sb_q[$];
    int    total  = 0;
    int    passed = 0;

    always #5 clk = ~clk;

    a_hist_buffer #(.DATA_W(16), .CH(2), .DEPTH(4), .CAPTURE_PHASE(4'd1)) dut (
        .clk(clk), .rst(rst), .step(step), .controller(controller), .flush(flush),
        .a_in(a_in), .rd_lag(rd_lag), .rd_data(rd_data), .rd_valid(rd_valid),
        .a_last(a_last), .count(count), .push(push)
    );

    task automatic expect_val(input string n, input int sel, input logic [31:0] e);
        item_t it;
        it.name = n;
        it.sel  = sel;
        it.exp  = e;
        sb_q.push_back(it);
    endtask

    task automatic expect_status(input string n, input logic [2:0] c, input logic [31:0] l, input logic p);
        expect_val({n, ".count"}, 3, 32'(c));
        expect_val({n, ".a_last"}, 2, l);
        expect_val({n, ".push"}, 4, 32'(p));
    endtask

    task automatic expect_read(input string n, input logic [31:0] d, input logic v);
        expect_val({n, ".rd_data"}, 0, d);
        expect_val({n, ".rd_valid"}, 1, 32'(v));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: compare every queued expectation against the settled outputs
    always @(negedge clk) begin
        item_t       it;
        logic [31:0] act;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            case (it.sel)
                0:       act = rd_data;
                1:       act = 32'(rd_valid);
                2:       act = a_last;
                3:       act = 32'(count);
                default: act = 32'(push);
            endcase
            total++;
            if (act !== it.exp) begin
                $display("FAIL %s: got 0x%08h expected 0x%08h", it.name, act, it.exp);
            end else begin
                passed++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; step = 4'd1; controller = 4'd1; flush = 1'b0;
        a_in = {16'h0800, 16'h0200}; rd_lag = 2'd0;
        tick(); tick(); tick();
        expect_status("reset", 3'd0, 32'h0, 1'b0);
        expect_read("reset", 32'h0, 1'b0);
        rst = 1'b0; step = 4'd0; controller = 4'd0;
        tick();
        expect_status("idle", 3'd0, 32'h0, 1'b0);

        // Hold the capture phase for three cycles on one step
        step = 4'd1; controller = 4'd1; a_in = {16'h0800, 16'h0200};
        tick();
        expect_status("hold1", 3'd1, 32'h08000200, 1'b1);
        tick();
`ifdef A_HIST_STEP_GUARD_EN
        expect_status("hold2", 3'd1, 32'h08000200, 1'b0);
`else
        expect_status("hold2", 3'd2, 32'h08000200, 1'b1);
`endif
        tick();
`ifdef A_HIST_STEP_GUARD_EN
        expect_status("hold3", 3'd1, 32'h08000200, 1'b0);
`else
        expect_status("hold3", 3'd3, 32'h08000200, 1'b1);
`endif
        controller = 4'd0; step = 4'd0;
        tick();
        expect_val("hold_end.push", 4, 32'h0);

        // Wrap and overwrite: five steps into four slots
        flush = 1'b1;
        tick();
        expect_status("flush0", 3'd0, 32'h0, 1'b0);
        expect_read("flush0", 32'h0, 1'b0);
        flush = 1'b0;
        for (int s = 1; s <= 5; s++) begin
            step = 4'(s); controller = 4'd1;
            a_in = {16'(16'h1000 + s), 16'(s * 256)};
            tick();
            expect_status($sformatf("wr%0d", s), 3'((s > 4) ? 4 : s), {16'(16'h1000 + s), 16'(s * 256)}, 1'b1);
        end
        controller = 4'd0; step = 4'd0;
        for (int k = 0; k < 4; k++) begin
            rd_lag = 2'(k);
            tick();
            expect_read($sformatf("wrap_lag%0d", k), {16'(16'h1000 + 5 - k), 16'((5 - k) * 256)}, 1'b1);
            expect_val($sformatf("wrap_lag%0d.count", k), 3, 32'd4);
        end

        // Lag boundary with two entries
        flush = 1'b1;
        tick();
        flush = 1'b0;
        step = 4'd1; controller = 4'd1; a_in = {16'h0000, 16'h0111};
        tick();
        step = 4'd2; a_in = {16'h0000, 16'h0222};
        tick();
        controller = 4'd0; step = 4'd0;
        rd_lag = 2'd3;
        tick();
        expect_read("lag3_of2", 32'h0, 1'b0);
        rd_lag = 2'd1;
        tick();
        expect_read("lag1_of2", 32'h00000111, 1'b1);
        rd_lag = 2'd2;
        tick();
        expect_read("lag2_of2", 32'h0, 1'b0);

        // Read and capture at the same edge returns pre-capture contents
        flush = 1'b1;
        tick();
        flush = 1'b0;
        step = 4'd1; controller = 4'd1; a_in = {16'h0000, 16'h0100};
        tick();
        step = 4'd2; a_in = {16'h0000, 16'h0800}; rd_lag = 2'd0;
        tick();
        expect_read("rw_same", 32'h00000100, 1'b1);
        expect_val("rw_same.count", 3, 32'd2);
        controller = 4'd0; step = 4'd0;
        tick();
        expect_read("rw_next", 32'h00000800, 1'b1);

        // Flush beats a simultaneous capture
        flush = 1'b1; step = 4'd3; controller = 4'd1; a_in = {16'h0000, 16'h0333};
        tick();
        expect_status("flush_cap", 3'd0, 32'h0, 1'b0);
        expect_read("flush_cap", 32'h0, 1'b0);
        flush = 1'b0; step = 4'd1;
        tick();
        expect_status("post_flush", 3'd1, 32'h00000333, 1'b1);
        controller = 4'd0; step = 4'd0;
        tick();
        expect_read("post_flush", 32'h00000333, 1'b1);

        // Reset in the middle of a step discards history
        rst = 1'b1; step = 4'd2; controller = 4'd1;
        tick();
        expect_status("mid_rst", 3'd0, 32'h0, 1'b0);
        expect_read("mid_rst", 32'h0, 1'b0);
        rst = 1'b0; step = 4'd0; controller = 4'd0;
        tick();
        expect_read("after_rst", 32'h0, 1'b0);

        tick();
        tick();
        total++;
        if (sb_q.size() != 0) begin
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end else begin
            passed++;
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
